// File: rtl/tick_timer.sv
// Programmable game-speed timer: emits a one-cycle TICK every PERIOD clocks,
// with MAXTIME resetting to the slowest speed and SETTIME stepping faster.
module tick_timer #(
    parameter int MAX_PERIOD = 25_000_000,
    parameter int MIN_PERIOD = 2_500_000,
    parameter int SHIFT      = 3,
    parameter int W          = 25
) (
    input  logic         CLK,
    input  logic         CLRN,
    input  logic         MAXTIME,
    input  logic         SETTIME,
    output logic         TICK,
    output logic [W-1:0] PERIOD,
    output logic [3:0]   LEVEL
);

    localparam logic [W-1:0] MAX_P = W'(MAX_PERIOD);
    localparam logic [W-1:0] MIN_P = W'(MIN_PERIOD);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0] period_q, period_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [3:0]   level_q, level_d;
    logic         tick_q, tick_d;
    logic [W-1:0] step;
    logic [W-1:0] next_period;

    // NOTE: combinational logic uses blocking '=' with every output defaulted
    // first, so no path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        step = period_q >> SHIFT;
        if (step == '0) begin
            step = ONE;
        end
        next_period = period_q - step;
        if (next_period < MIN_P) begin
            next_period = MIN_P;
        end

        period_d = period_q;
        cnt_d    = cnt_q;
        level_d  = level_q;
        tick_d   = 1'b0;

        // A load always wins over a pending tick.
        if (MAXTIME) begin
            period_d = MAX_P;
            cnt_d    = MAX_P - ONE;
            level_d  = 4'd0;
        end else if (SETTIME) begin
            period_d = next_period;
            cnt_d    = next_period - ONE;
            level_d  = (level_q == 4'd15) ? level_q : level_q + 4'd1;
        end else if (cnt_q != '0) begin
            cnt_d    = cnt_q - ONE;
        end else begin
            tick_d   = 1'b1;
            cnt_d    = period_q - ONE;
        end
    end

    // NOTE: state registers use non-blocking '<=' so all flops update together;
    // the reset here is sampled on the clock edge, not asynchronous.
    always_ff @(posedge CLK) begin
        if (!CLRN) begin
            period_q <= MAX_P;
            cnt_q    <= MAX_P - ONE;
            level_q  <= 4'd0;
            tick_q   <= 1'b0;
        end else begin
            period_q <= period_d;
            cnt_q    <= cnt_d;
            level_q  <= level_d;
            tick_q   <= tick_d;
        end
    end

    assign TICK   = tick_q;
    assign PERIOD = period_q;
    assign LEVEL  = level_q;

endmodule

// File: tb/tb_tick_timer.sv
// Self-checking bench for tick_timer: hand-derived vector table, directed
// sequences and randomized traffic, all compared against a cycle-phase model.
module tb_tick_timer;

    localparam int MAX_PERIOD = 16;
    localparam int MIN_PERIOD = 4;
    localparam int SHIFT      = 2;
    localparam int W          = 5;

    logic         CLK = 1'b0;
    logic         CLRN = 1'b0;
    logic         MAXTIME = 1'b0;
    logic         SETTIME = 1'b0;
    logic         TICK;
    logic [W-1:0] PERIOD;
    logic [3:0]   LEVEL;

    tick_timer #(
        .MAX_PERIOD(MAX_PERIOD),
        .MIN_PERIOD(MIN_PERIOD),
        .SHIFT     (SHIFT),
        .W         (W)
    ) dut (
        .CLK    (CLK),
        .CLRN   (CLRN),
        .MAXTIME(MAXTIME),
        .SETTIME(SETTIME),
        .TICK   (TICK),
        .PERIOD (PERIOD),
        .LEVEL  (LEVEL)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic rst_n;
        logic max_t;
        logic set_t;
        logic exp_tick;
        int   exp_period;
        int   exp_level;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_mis = 0;

    // Reference model: the timer as "edges elapsed since the last load";
    // a tick lands on every whole multiple of the current period.
    int   m_period = MAX_PERIOD;
    int   m_level  = 0;
    int   m_phase  = 0;
    logic m_tick   = 1'b0;

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic m, input logic s);
        int d;
        int np;
        if (!r || m) begin
            m_period = MAX_PERIOD;
            m_level  = 0;
            m_phase  = 0;
            m_tick   = 1'b0;
        end else if (s) begin
            d  = m_period / (2 ** SHIFT);
            if (d == 0) d = 1;
            np = m_period - d;
            if (np < MIN_PERIOD) np = MIN_PERIOD;
            m_period = np;
            m_level  = (m_level + 1 > 15) ? 15 : m_level + 1;
            m_phase  = 0;
            m_tick   = 1'b0;
        end else begin
            m_phase++;
            m_tick = (m_phase % m_period) == 0;
        end
    endtask

    // Drive at the falling edge, let one rising edge happen, sample at the next fall.
    task automatic cycle(input logic r, input logic m, input logic s);
        CLRN    = r;
        MAXTIME = m;
        SETTIME = s;
        @(posedge CLK);
        model_edge(r, m, s);
        @(negedge CLK);
        check("model_tick",   int'(TICK),   int'(m_tick));
        check("model_period", int'(PERIOD), m_period);
        check("model_level",  int'(LEVEL),  m_level);
    endtask

    task automatic add(input logic r, input logic m, input logic s, input logic t,
                       input int p, input int l, input int n = 1);
        vec_t v;
        v.rst_n = r; v.max_t = m; v.set_t = s;
        v.exp_tick = t; v.exp_period = p; v.exp_level = l;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run exceeded time limit, got 1, expected 0");
        $fatal(1);
    end

    initial begin
        // Reset and free run at the slowest period: ticks 16 edges after the load.
        add(0, 0, 0, 0, 16, 0);
        add(1, 0, 0, 0, 16, 0, 15);
        add(1, 0, 0, 1, 16, 0);
        add(1, 0, 0, 0, 16, 0, 15);
        add(1, 0, 0, 1, 16, 0);
        // SETTIME mid-count: period 12, ticks 12 apart.
        add(1, 0, 0, 0, 16, 0, 5);
        add(1, 0, 1, 0, 12, 1);
        add(1, 0, 0, 0, 12, 1, 11);
        add(1, 0, 0, 1, 12, 1);
        add(1, 0, 0, 0, 12, 1, 11);
        add(1, 0, 0, 1, 12, 1);
        // SETTIME on the edge where the counter is zero suppresses that tick.
        add(1, 0, 0, 0, 12, 1, 11);
        add(1, 0, 1, 0, 9, 2);
        add(1, 0, 0, 0, 9, 2, 8);
        add(1, 0, 0, 1, 9, 2);
        add(1, 0, 1, 0, 7, 3);
        // MAXTIME together with SETTIME: MAXTIME wins; held MAXTIME never ticks.
        add(1, 1, 1, 0, 16, 0);
        add(1, 1, 0, 0, 16, 0, 40);
        add(1, 0, 0, 0, 16, 0, 15);
        add(1, 0, 0, 1, 16, 0);
        // Step down to period 5, then a one-edge reset mid-count.
        add(1, 0, 1, 0, 12, 1);
        add(1, 0, 1, 0, 9, 2);
        add(1, 0, 1, 0, 7, 3);
        add(1, 0, 1, 0, 6, 4);
        add(1, 0, 1, 0, 5, 5);
        add(1, 0, 0, 0, 5, 5, 2);
        add(0, 0, 0, 0, 16, 0);
        add(1, 0, 0, 0, 16, 0, 15);
        add(1, 0, 0, 1, 16, 0);
        add(1, 0, 0, 0, 16, 0);

        @(negedge CLK);
        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rst_n, vecs[i].max_t, vecs[i].set_t);
            check("vec_tick",   int'(TICK),   int'(vecs[i].exp_tick));
            check("vec_period", int'(PERIOD), vecs[i].exp_period);
            check("vec_level",  int'(LEVEL),  vecs[i].exp_level);
        end

        // Ten SETTIMEs 20 cycles apart walk the period down to the floor.
        cycle(1, 1, 0);
        for (int k = 0; k < 10; k++) begin
            cycle(1, 0, 1);
            for (int j = 0; j < 19; j++) cycle(1, 0, 0);
        end
        check("floor_period", int'(PERIOD), MIN_PERIOD);
        check("floor_level",  int'(LEVEL),  10);

        // Twenty SETTIMEs back to back saturate the level counter.
        for (int k = 0; k < 20; k++) cycle(1, 0, 1);
        check("sat_level", int'(LEVEL), 15);
        for (int j = 0; j < 12; j++) cycle(1, 0, 0);

        // Randomized traffic, including occasional resets and reloads.
        for (int i = 0; i < 3000; i++) begin
            logic r, m, s;
            r = ($urandom_range(0, 199) != 0);
            m = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 11) == 0);
            cycle(r, m, s);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
